// File: rtl/alu_op_sequencer_pkg.sv
// Shared ALU definitions: opcode constants, sequencer state encoding and opcode classification helpers.
package alu_op_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OPC_W  = 16;

    localparam logic [OP_W-1:0] OP_ADD         = 4'd0;
    localparam logic [OP_W-1:0] OP_MUL         = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB         = 4'd2;
    localparam logic [OP_W-1:0] OP_SHL         = 4'd3;
    localparam logic [OP_W-1:0] OP_SHR         = 4'd4;
    localparam logic [OP_W-1:0] OP_SAR         = 4'd5;
    localparam logic [OP_W-1:0] OP_AND         = 4'd6;
    localparam logic [OP_W-1:0] OP_OR          = 4'd7;
    localparam logic [OP_W-1:0] OP_NOT         = 4'd8;
    localparam logic [OP_W-1:0] OP_XOR         = 4'd9;
    localparam logic [OP_W-1:0] OP_DIV         = 4'd10;
    localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } seq_state_e;

    function automatic logic is_slow_op(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return op >= OP_ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_settle_counter.sv
// Down-counter timing the ALU settle window: loads N-1 on acceptance, decrements while enabled, flags zero.
module settle_counter
    import alu_op_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time through an external combinational ALU, waits a per-opcode settle time,
// then holds the captured result until the consumer takes it.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned FAST_CYCLES = 1,
    parameter int unsigned SLOW_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_control,
    input  logic [DATA_W-1:0] alu_s,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_s,
    output logic              rsp_carry,
    output logic              rsp_overflow,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              busy,
    output logic [OPC_W-1:0]  op_count
);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_b_q, rsp_s_q;
    logic [OP_W-1:0]   alu_ctrl_q;
    logic              rsp_carry_q, rsp_overflow_q, rsp_zero_q, rsp_illegal_q;
    logic [OPC_W-1:0]  op_count_q;
    logic              accept, rsp_hs, capture, cnt_zero, cnt_dec;
    logic [CNT_W-1:0]  cnt_load_val;

    assign accept  = cmd_valid && cmd_ready;
    assign rsp_hs  = rsp_valid && rsp_ready;
    assign capture = (state_q == ST_SETTLE) && cnt_zero;
    assign cnt_dec = (state_q == ST_SETTLE);

    assign cnt_load_val = is_slow_op(cmd_op) ? CNT_W'(SLOW_CYCLES - 1) : CNT_W'(FAST_CYCLES - 1);

    settle_counter u_settle_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = is_illegal_op(cmd_op) ? ST_RESP : ST_SETTLE;
            ST_SETTLE: if (cnt_zero) state_d = ST_RESP;
            ST_RESP:   if (rsp_hs) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
    end

    // Illegal opcodes still register operands, but the response is forced to zero with the marker set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_ctrl_q     <= '0;
            rsp_s_q        <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_illegal_q  <= 1'b0;
            op_count_q     <= '0;
        end else begin
            if (accept) begin
                alu_a_q    <= cmd_a;
                alu_b_q    <= cmd_b;
                alu_ctrl_q <= cmd_op;
                if (is_illegal_op(cmd_op)) begin
                    rsp_s_q        <= '0;
                    rsp_carry_q    <= 1'b0;
                    rsp_overflow_q <= 1'b0;
                    rsp_zero_q     <= 1'b0;
                    rsp_illegal_q  <= 1'b1;
                end
            end
            if (capture) begin
                rsp_s_q        <= alu_s;
                rsp_carry_q    <= alu_carry;
                rsp_overflow_q <= alu_overflow;
                rsp_zero_q     <= alu_zero;
                rsp_illegal_q  <= 1'b0;
            end
            if (rsp_hs) begin
                op_count_q <= op_count_q + 1'b1;
            end
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_control  = alu_ctrl_q;
    assign rsp_s        = rsp_s_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_illegal  = rsp_illegal_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural ALU sits on the alu_* bus; expected responses are queued at acceptance.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int unsigned FAST = 1;
    localparam int unsigned SLOW = 4;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        ill;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [31:0] alu_a, alu_b, alu_s;
    logic [3:0]  alu_control;
    logic        alu_carry, alu_overflow, alu_zero;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_s;
    logic        rsp_carry, rsp_overflow, rsp_zero, rsp_illegal;
    logic        busy;
    logic [15:0] op_count;

    int unsigned n_tests = 0, n_fail = 0;
    logic [15:0] exp_cnt = '0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(.FAST_CYCLES(FAST), .SLOW_CYCLES(SLOW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_s(alu_s), .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .busy(busy), .op_count(op_count)
    );

    function automatic exp_t alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] w;
        e = '{s: '0, c: 1'b0, v: 1'b0, z: 1'b0, ill: 1'b0, lat: 0};
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; e.s = w[31:0]; e.c = w[32];
                        e.v = (a[31] == b[31]) && (e.s[31] != a[31]); end
            4'd1: e.s = a * b;
            4'd2: begin e.s = a - b; e.c = (a < b); e.v = (a[31] != b[31]) && (e.s[31] != a[31]); end
            4'd3: e.s = a << b[4:0];
            4'd4: e.s = a >> b[4:0];
            4'd5: e.s = $signed(a) >>> b[4:0];
            4'd6: e.s = a & b;
            4'd7: e.s = a | b;
            4'd8: e.s = ~a;
            4'd9: e.s = a ^ b;
            4'd10: e.s = (b == 0) ? '1 : a / b;
            default: e.s = '0;
        endcase
        e.z = (e.s == 0);
        return e;
    endfunction

    // Stand-in for the external combinational ALU.
    always_comb begin
        exp_t r;
        r = alu_model(alu_control, alu_a, alu_b);
        alu_s        = r.s;
        alu_carry    = r.c;
        alu_overflow = r.v;
        alu_zero     = r.z;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int unsigned hold);
        exp_t        e, got;
        int unsigned lat;
        check("cmd_ready_idle", {31'b0, cmd_ready}, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        e = alu_model(op, a, b);
        if (op >= 4'd11) begin
            e = '{s: '0, c: 1'b0, v: 1'b0, z: 1'b0, ill: 1'b1, lat: 0};
        end else begin
            e.lat = (op == 4'd1 || op == 4'd10) ? SLOW : FAST;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_a = ~a; cmd_b = a ^ 32'h5A5A_5A5A;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            check("busy_settle", {31'b0, busy}, 1);
            check("alu_a_settle", alu_a, a);
            check("alu_b_settle", alu_b, b);
            check("alu_ctl_settle", {28'b0, alu_control}, {28'b0, op});
            @(posedge clk); #1;
            lat++;
        end
        got = sb.pop_front();
        check("latency", lat, got.lat);
        check("rsp_s", rsp_s, got.s);
        check("rsp_flags", {28'b0, rsp_carry, rsp_overflow, rsp_zero, rsp_illegal},
              {28'b0, got.c, got.v, got.z, got.ill});
        check("alu_ctl_resp", {28'b0, alu_control}, {28'b0, op});
        for (int i = 0; i < int'(hold); i++) begin
            cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 32'h1111_1111; cmd_b = 32'h2222_2222;
            @(posedge clk); #1;
            check("hold_valid", {31'b0, rsp_valid}, 1);
            check("hold_ready", {31'b0, cmd_ready}, 0);
            check("hold_s", rsp_s, got.s);
            check("hold_ill", {31'b0, rsp_illegal}, {31'b0, got.ill});
            check("hold_alu_a", alu_a, a);
            check("hold_cnt", {16'b0, op_count}, {16'b0, exp_cnt});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check("op_count", {16'b0, op_count}, {16'b0, exp_cnt});
        check("post_valid", {31'b0, rsp_valid}, 0);
        check("post_ready", {31'b0, cmd_ready}, 1);
    endtask

    typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; int unsigned hold; } stim_t;
    stim_t tbl[$];

    initial begin
        tbl.push_back('{4'd0,  32'hFFFF_FFFF, 32'd1,          0});
        tbl.push_back('{4'd10, 32'd100,       32'd7,          3});
        tbl.push_back('{4'hF,  32'd5,         32'd9,          0});
        tbl.push_back('{4'd2,  32'd5,         32'd7,          1});
        tbl.push_back('{4'd1,  32'd1234,      32'd5678,       0});
        tbl.push_back('{4'd0,  32'h7FFF_FFFF, 32'd1,          0});
        tbl.push_back('{4'd5,  32'h8000_0000, 32'd4,          0});
        tbl.push_back('{4'd3,  32'h0000_0003, 32'd30,         0});
        tbl.push_back('{4'd4,  32'hF000_0000, 32'd8,          0});
        tbl.push_back('{4'd6,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  0});
        tbl.push_back('{4'd7,  32'h1200_0000, 32'h0000_0034,  0});
        tbl.push_back('{4'd8,  32'h0000_FFFF, 32'd0,          0});
        tbl.push_back('{4'd9,  32'hDEAD_BEEF, 32'hDEAD_BEEF,  0});
        tbl.push_back('{4'd11, 32'h1234_5678, 32'h9ABC_DEF0,  2});

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, cmd_ready}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_valid", {31'b0, rsp_valid}, 0);
        check("rst_count", {16'b0, op_count}, 0);
        check("rst_alu", alu_a | alu_b | {28'b0, alu_control}, 0);
        check("rst_rsp", rsp_s | {28'b0, rsp_carry, rsp_overflow, rsp_zero, rsp_illegal}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[k]) run_op(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].hold);

        // Abort a MUL in its second settle cycle.
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 32'd77; cmd_b = 32'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        check("mid_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        check("arst_ready", {31'b0, cmd_ready}, 1);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_valid", {31'b0, rsp_valid}, 0);
        check("arst_count", {16'b0, op_count}, 0);
        check("arst_alu", alu_a | alu_b | {28'b0, alu_control}, 0);
        check("arst_rsp", rsp_s | {28'b0, rsp_carry, rsp_overflow, rsp_zero, rsp_illegal}, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("arst_no_rsp", {31'b0, rsp_valid}, 0);
            check("arst_rdy_after", {31'b0, cmd_ready}, 1);
            check("arst_cnt_after", {16'b0, op_count}, 0);
        end

        run_op(4'd1, 32'd77, 32'd3, 0);

        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        exp_cnt = 16'hFFFE;
        #1;
        run_op(4'hC, 32'd1, 32'd2, 0);
        check("cnt_ffff", {16'b0, op_count}, 32'h0000_FFFF);
        run_op(4'd0, 32'd3, 32'd4, 0);
        check("cnt_wrap", {16'b0, op_count}, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
